// File: rtl/lsu_if.sv
// Data memory bus between the LSU (master) and the data memory (slave).
// Request fields are driven by the LSU; grant, read-valid and read data
// come back from the memory.
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: captures the execute stage into a stage register,
// issues at most one data-memory access for slot 0, formats load data,
// and presents forwarding/writeback pairs for both issue slots.
module lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid0_i,
  input  logic        valid1_i,
  input  logic [31:0] alu0_i,
  input  logic [31:0] alu1_i,
  input  logic [31:0] store_data_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic        rd_we0_i,
  input  logic [4:0]  rd0_i,
  input  logic        rd_we1_i,
  input  logic [4:0]  rd1_i,
  output logic        stall_o,
  output logic        wm0_o,
  output logic [4:0]  am0_o,
  output logic [31:0] bypass_lsu0_o,
  output logic        wm1_o,
  output logic [4:0]  am1_o,
  output logic [31:0] bypass_lsu1_o,
  output logic        misalign_o,
  lsu_if.master       dmem
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  typedef struct packed {
    logic        valid0;
    logic        valid1;
    logic [31:0] alu0;
    logic [31:0] alu1;
    logic [31:0] store_data;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic        rd_we0;
    logic [4:0]  rd0;
    logic        rd_we1;
    logic [4:0]  rd1;
  } stage_t;

  // Halfword needs an even address, word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  // Byte enables for the accessed lanes.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the byte enables pick it out.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   store_lanes = {4{sd[7:0]}};
      2'b01:   store_lanes = {2{sd[15:0]}};
      default: store_lanes = sd;
    endcase
  endfunction

  // Select the addressed lane and sign/zero extend it.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'h000000, lane[7:0]};
      3'b101:  load_fmt = {16'h0000, lane[15:0]};
      default: load_fmt = rdata;
    endcase
  endfunction

  stage_t      in_s;
  stage_t      stage_q, stage_d;
  state_e      state_q, state_d;
  logic [31:0] ldata_q, ldata_d;
  logic        stall_s;
  logic        capture_s;
  logic        in_go_s;
  logic        r_mis_s;

  // Gather execute inputs into one stage record.
  always_comb begin
    in_s            = '0;
    in_s.valid0     = valid0_i;
    in_s.valid1     = valid1_i;
    in_s.alu0       = alu0_i;
    in_s.alu1       = alu1_i;
    in_s.store_data = store_data_i;
    in_s.is_load    = is_load_i;
    in_s.is_store   = is_store_i;
    in_s.funct3     = funct3_i;
    in_s.rd_we0     = rd_we0_i;
    in_s.rd0        = rd0_i;
    in_s.rd_we1     = rd_we1_i;
    in_s.rd1        = rd1_i;
  end

  // Stall while a request waits for grant (a granted store releases at once) or a load waits for data.
  always_comb begin
    stall_s   = ((state_q == REQ) && !(stage_q.is_store && dmem.gnt)) || (state_q == WAIT);
    capture_s = !stall_s;
    in_go_s   = in_s.valid0 && (in_s.is_load || in_s.is_store) &&
                !is_misaligned(in_s.funct3, in_s.alu0[1:0]);
    r_mis_s   = stage_q.valid0 && (stage_q.is_load || stage_q.is_store) &&
                is_misaligned(stage_q.funct3, stage_q.alu0[1:0]);
  end

  // Stage register and load-data holding register next values.
  always_comb begin
    if (capture_s) begin
      stage_d = in_s;
    end else begin
      stage_d = stage_q;
    end
    if ((state_q == WAIT) && dmem.rvalid) begin
      ldata_d = load_fmt(stage_q.funct3, stage_q.alu0[1:0], dmem.rdata);
    end else begin
      ldata_d = ldata_q;
    end
  end

  // Stage and load-data flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
      ldata_q <= 32'h0000_0000;
    end else begin
      stage_q <= stage_d;
      ldata_q <= ldata_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a capture always restarts; otherwise advance the pending access.
  always_comb begin
    state_d = state_q;
    if (capture_s) begin
      if (in_go_s) begin
        state_d = REQ;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        REQ: begin
          if (dmem.gnt && stage_q.is_load) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (dmem.rvalid) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: memory request fields, stall and forwarding pairs.
  always_comb begin
    dmem.req      = 1'b0;
    dmem.we       = 1'b0;
    dmem.be       = 4'b0000;
    dmem.addr     = 32'h0000_0000;
    dmem.wdata    = 32'h0000_0000;
    if (state_q == REQ) begin
      dmem.req   = 1'b1;
      dmem.we    = stage_q.is_store;
      dmem.be    = byte_en(stage_q.funct3, stage_q.alu0[1:0]);
      dmem.addr  = {stage_q.alu0[31:2], 2'b00};
      dmem.wdata = stage_q.is_store ? store_lanes(stage_q.funct3, stage_q.store_data)
                                    : 32'h0000_0000;
    end else begin
      dmem.req   = 1'b0;
    end
    stall_o       = stall_s;
    misalign_o    = r_mis_s;
    wm0_o         = stage_q.valid0 && stage_q.rd_we0 && (stage_q.rd0 != 5'd0) && !r_mis_s &&
                    (!stage_q.is_load || (state_q == DONE));
    am0_o         = stage_q.rd0;
    bypass_lsu0_o = stage_q.is_load ? ldata_q : stage_q.alu0;
    wm1_o         = stage_q.valid1 && stage_q.rd_we1 && (stage_q.rd1 != 5'd0);
    am1_o         = stage_q.rd1;
    bypass_lsu1_o = stage_q.alu1;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 No parameters.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 valid0_i / valid1_i  in  1 each  execute slot 0 / slot 1 instruction valid.
REQ-005 alu0_i / alu1_i  in  32 each  execute ALU results; alu0_i is the effective address for memory ops.
REQ-006 store_data_i  in  32  bypassed rs2 of slot 0.
REQ-007 is_load_i / is_store_i  in  1 each  slot 0 memory op; never both high.
REQ-008 funct3_i  in  3  slot 0 access size/sign (LB,LH,LW,LBU,LHU,SB,SH,SW encodings).
REQ-009 rd_we0_i / rd0_i, rd_we1_i / rd1_i  in  1 / 5 each  destination write enable and address per slot.
REQ-010 stall_o  out  1  execute must hold its contents; lsu captures nothing while high.
REQ-011 wm0_o / am0_o / bypass_lsu0_o  out  1 / 5 / 32  slot 0 forwarding and writeback (write, address, data).
REQ-012 wm1_o / am1_o / bypass_lsu1_o  out  1 / 5 / 32  slot 1 forwarding and writeback.
REQ-013 misalign_o  out  1  one-cycle pulse on misaligned access.
REQ-014 dmem_req_o / dmem_we_o / dmem_be_o / dmem_addr_o / dmem_wdata_o  out  1 / 1 / 4 / 32 / 32  data memory request.
REQ-015 dmem_gnt_i / dmem_rvalid_i / dmem_rdata_i  in  1 / 1 / 32  request accepted; read data valid; read data.

Function
REQ-016 Stage register R captures all execute inputs on each rising edge where stall_o=0; it holds its value otherwise.
REQ-017 FSM states: IDLE, REQ, WAIT, DONE.
REQ-018 Entry from any state when capturing:
- aligned valid0 load/store -> REQ.
- otherwise -> IDLE.
REQ-019 REQ:
- dmem_req_o=1, all request fields held stable until dmem_gnt_i.
- store & gnt -> IDLE.
- load & gnt -> WAIT.
REQ-020 WAIT: dmem_req_o=0; on dmem_rvalid_i, formatted read data latched into LDATA and state -> DONE. rvalid arrives at least one cycle after gnt.
REQ-021 DONE: holds LDATA; exits only via a capture.
REQ-022 stall_o = (state==REQ and not (store and dmem_gnt_i)) or state==WAIT; stall_o is 0 in IDLE and DONE.
REQ-023 Address: dmem_addr_o = {alu0[31:2],2'b00}.
REQ-024 Byte enables: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<addr[1:0]; SW -> 4'b1111.
REQ-025 Write data: dmem_wdata_o replicates store data across lanes (byte x4, half x2). dmem_we_o = store.
REQ-026 Load formatting selects lane by addr[1:0]:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the full word.
REQ-027 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- No dmem request; state -> IDLE.
- misalign_o=1 for the single cycle after capture.
- wm0_o suppressed.
REQ-028 Slot 0 outputs:
- wm0_o = R.valid0 & R.rd_we0 & (rd0!=0) & not misaligned & (non-load or state==DONE).
- bypass_lsu0_o = LDATA for loads, else R.alu0.
REQ-029 Slot 1 outputs: wm1_o = R.valid1 & R.rd_we1 & (rd1!=0); bypass_lsu1_o = R.alu1; am1_o = R.rd1.
REQ-030 Each output pair is reported once per instruction. Back-to-back memory ops: the op completing at store-gnt or in DONE is replaced by the next capture on the same edge.
REQ-031 Non-memory slot 0 ops complete in one cycle (zero stall).

Reset
REQ-032 While rst_i high:
- state=IDLE; R valid bits, LDATA and all R fields = 0.
- every output = 0, including stall_o, dmem_req_o and misalign_o.
REQ-033 Reset asserted mid-transaction (REQ/WAIT) abandons it; any rvalid after reset release is ignored while in IDLE.

Verification
REQ-034 ADD x5 in slot 0, alu0=0x10 -> next cycle wm0_o=1, am0_o=5, bypass_lsu0_o=0x10, stall_o=0.
REQ-035 SW addr 0x100, data 0xDEADBEEF, gnt delayed 2 cycles -> req held 3 cycles, be=4'hF, addr=0x100, stall_o high 2 cycles then low on the gnt cycle.
REQ-036 LB x7 addr 0x203, rdata 0x80000000, gnt immediate, rvalid 1 cycle later -> DONE with bypass_lsu0_o=0xFFFFFF80, wm0_o=1, am0_o=7.
REQ-037 LHU addr 0x202, rdata 0xBEEF1234 -> bypass_lsu0_o=0x0000BEEF.
REQ-038 LW addr 0x101 -> misalign_o pulse, no dmem_req_o, wm0_o=0.
REQ-039 rst_i pulsed while in WAIT, then rvalid -> all outputs 0, state IDLE, no write reported.
